// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory slave for the core load/store port.
// Ports: clk, reset (sync, active-high); req_* valid/ready request channel
// (addr, we, wdata, be); resp_* valid/ready response channel (rdata, err);
// err_count: saturating count of error responses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  err_count
);

    localparam int unsigned AW =
        (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW =
        (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          enter_resp;

    logic [31:0]   addr_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    logic [31:0]   cur_addr;
    logic          cur_we;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_be;
    logic [31:0]   off;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic          fire;

    logic [31:0]   mem [DEPTH_WORDS];

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign fire       = req_valid && req_ready;

    // With zero latency the commit happens on the accept edge, before the
    // capture registers are loaded, so the live request is used in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_addr  = req_addr;
            cur_we    = req_we;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    // Offset compare is done at 33 bits so the range check cannot wrap.
    assign off      = cur_addr - BASE_ADDR;
    assign addr_err = (cur_addr[1:0] != 2'b00)
                   || (cur_addr < BASE_ADDR)
                   || ({1'b0, off} >= LIMIT);
    assign idx      = off[AW+1:2];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE: begin
                if (fire) begin
                    if (LATENCY == 0) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (fire) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (enter_resp) begin
                resp_err <= addr_err;
                if (!addr_err && !cur_we) begin
                    resp_rdata <= mem[idx];
                end else begin
                    resp_rdata <= '0;
                end
                if (addr_err && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    // Contents are not reset; a reset edge blocks any pending commit.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && !addr_err && cur_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_be[b]) begin
                    mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: drives a LATENCY=2 and a LATENCY=0 responder against a
// transaction-level model; directed vectors plus literal expectations.
module tb_dmem_responder;

    localparam int          L0 = 2;
    localparam int          L1 = 0;
    localparam logic [31:0] B0 = 32'h0;
    localparam logic [31:0] B1 = 32'h100;
    localparam int          D0 = 1024;
    localparam int          D1 = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rv  [2];
    logic        rr  [2];
    logic [31:0] ra  [2];
    logic        rwe [2];
    logic [31:0] rwd [2];
    logic [3:0]  rbe [2];
    logic        sv  [2];
    logic        sr  [2];
    logic [31:0] sd  [2];
    logic        se  [2];
    logic [7:0]  ec  [2];

    int vectors = 0;
    int miscompares = 0;

    dmem_responder #(.DEPTH_WORDS(D0), .LATENCY(L0), .BASE_ADDR(B0)) u_dut0 (
        .clk(clk), .reset(rst[0]),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_addr(ra[0]),
        .req_we(rwe[0]), .req_wdata(rwd[0]), .req_be(rbe[0]),
        .resp_valid(sv[0]), .resp_ready(sr[0]), .resp_rdata(sd[0]),
        .resp_err(se[0]), .err_count(ec[0])
    );

    dmem_responder #(.DEPTH_WORDS(D1), .LATENCY(L1), .BASE_ADDR(B1)) u_dut1 (
        .clk(clk), .reset(rst[1]),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_addr(ra[1]),
        .req_we(rwe[1]), .req_wdata(rwd[1]), .req_be(rbe[1]),
        .resp_valid(sv[1]), .resp_ready(sr[1]), .resp_rdata(sd[1]),
        .resp_err(se[1]), .err_count(ec[1])
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void timeout(string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out @%0t", nm, $time);
    endfunction

    // ---------------- transaction-level model ----------------
    int          n_edge = 0;
    bit          pend [2];
    bit          pres [2];
    int          due  [2];
    logic [31:0] m_a  [2];
    logic        m_we [2];
    logic [31:0] m_wd [2];
    logic [3:0]  m_be [2];
    logic [31:0] x_rd [2];
    logic        x_er [2];
    int          x_ec [2];
    logic [31:0] mm [int];

    function automatic bit is_err(int i, logic [31:0] a);
        longint base  = (i == 0) ? longint'(B0) : longint'(B1);
        longint depth = (i == 0) ? D0 : D1;
        longint la    = longint'(a);
        return (a[1:0] != 2'b00) || (la < base) || ((la - base) >= 4 * depth);
    endfunction

    function automatic int key(int i, logic [31:0] a);
        longint base = (i == 0) ? longint'(B0) : longint'(B1);
        return i * (1 << 20) + int'((longint'(a) - base) / 4);
    endfunction

    task automatic commit(int i);
        int k;
        logic [31:0] w;
        x_er[i] = is_err(i, m_a[i]);
        x_rd[i] = 32'h0;
        if (x_er[i]) begin
            if (x_ec[i] < 255) x_ec[i]++;
        end else begin
            k = key(i, m_a[i]);
            w = mm.exists(k) ? mm[k] : 32'h0;
            if (m_we[i]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[i][b]) w[8*b +: 8] = m_wd[i][8*b +: 8];
                mm[k] = w;
            end else begin
                x_rd[i] = w;
            end
        end
    endtask

    task automatic step(int i);
        int lat = (i == 0) ? L0 : L1;
        if (rst[i]) begin
            pend[i] = 0;
            pres[i] = 0;
            x_ec[i] = 0;
        end else begin
            if (pres[i]) begin
                if (sr[i]) pres[i] = 0;
            end else if (!pend[i] && rv[i]) begin
                pend[i] = 1;
                due[i]  = n_edge + lat;
                m_a[i]  = ra[i];
                m_we[i] = rwe[i];
                m_wd[i] = rwd[i];
                m_be[i] = rbe[i];
            end
            if (pend[i] && n_edge == due[i]) begin
                pend[i] = 0;
                pres[i] = 1;
                commit(i);
            end
        end
    endtask

    always @(posedge clk) begin
        n_edge++;
        step(0);
        step(1);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d resp_valid", i), 32'(sv[i]), 32'(pres[i]));
            chk($sformatf("u%0d req_ready", i), 32'(rr[i]),
                32'(!pend[i] && !pres[i] && !rst[i]));
            chk($sformatf("u%0d err_count", i), 32'(ec[i]), 32'(x_ec[i]));
            if (pres[i]) begin
                chk($sformatf("u%0d resp_rdata", i), sd[i], x_rd[i]);
                chk($sformatf("u%0d resp_err", i), 32'(se[i]), 32'(x_er[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn(input int i, input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, input bit pulse,
                       output logic [31:0] rd, output logic er,
                       output int lc);
        int k;
        @(negedge clk);
        ra[i] = a; rwe[i] = we; rwd[i] = wd; rbe[i] = be; rv[i] = 1'b1;
        k = 0;
        while (!rr[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) timeout("req_ready");
        @(negedge clk);
        rv[i] = 1'b0;
        lc = 1;
        while (!sv[i] && lc < 20) begin
            @(negedge clk);
            lc++;
        end
        if (lc == 20) timeout("resp_valid");
        rd = sd[i];
        er = se[i];
        for (int h = 0; h < hold; h++) begin
            if (pulse && h == 1) begin
                ra[i] = a; rwe[i] = 1'b1; rwd[i] = 32'h0; rbe[i] = 4'hF;
                rv[i] = 1'b1;
            end
            @(negedge clk);
            rv[i] = 1'b0;
            chk("hold resp_valid", 32'(sv[i]), 32'd1);
            chk("hold rdata", sd[i], rd);
            chk("hold err", 32'(se[i]), 32'(er));
            chk("hold req_ready", 32'(rr[i]), 32'd0);
        end
        sr[i] = 1'b1;
        @(negedge clk);
        sr[i] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lc;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; rv[i] = 1'b0; ra[i] = '0; rwe[i] = 1'b0;
            rwd[i] = '0; rbe[i] = '0; sr[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset req_ready", 32'(rr[0]), 32'd0);
        chk("reset resp_valid", 32'(sv[0]), 32'd0);
        chk("reset rdata", sd[0], 32'h0);
        chk("reset err", 32'(se[0]), 32'd0);
        chk("reset err_count", 32'(ec[0]), 32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        chk("idle req_ready", 32'(rr[0]), 32'd1);

        // store then load, 3-cycle response
        txn(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lc);
        chk("t1 store lat", 32'(lc), 32'd3);
        chk("t1 store rdata", rd, 32'h0);
        txn(0, 32'h10, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t1 load lat", 32'(lc), 32'd3);
        chk("t1 load rdata", rd, 32'hDEADBEEF);
        chk("t1 load err", 32'(er), 32'd0);

        // byte lanes
        txn(0, 32'h10, 1, 32'h11223344, 4'b0101, 0, 0, rd, er, lc);
        txn(0, 32'h10, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t2 lanes", rd, 32'hDE22BE44);

        // errors
        txn(0, 32'h0, 1, 32'hA5A5A5A5, 4'hF, 0, 0, rd, er, lc);
        txn(0, 32'hFFC, 1, 32'h5A5A5A5A, 4'hF, 0, 0, rd, er, lc);
        txn(0, 32'h13, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t3 misaligned err", 32'(er), 32'd1);
        chk("t3 misaligned rdata", rd, 32'h0);
        txn(0, 32'h1000, 1, 32'hFFFFFFFF, 4'hF, 0, 0, rd, er, lc);
        chk("t3 range err", 32'(er), 32'd1);
        txn(0, 32'h0, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t3 word0", rd, 32'hA5A5A5A5);
        txn(0, 32'hFFC, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t3 word1023", rd, 32'h5A5A5A5A);
        chk("t3 err_count", 32'(ec[0]), 32'd2);

        // backpressure with an ignored request pulse
        txn(0, 32'h10, 0, 32'h0, 4'h0, 5, 1, rd, er, lc);
        chk("t4 rdata", rd, 32'hDE22BE44);
        txn(0, 32'h10, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t4 pulse ignored", rd, 32'hDE22BE44);

        // reset during WAIT of a store
        txn(0, 32'h20, 1, 32'h12345678, 4'hF, 0, 0, rd, er, lc);
        @(negedge clk);
        ra[0] = 32'h20; rwe[0] = 1'b1; rwd[0] = 32'hCAFEF00D; rbe[0] = 4'hF;
        rv[0] = 1'b1;
        @(negedge clk);
        rv[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("t5 resp_valid", 32'(sv[0]), 32'd0);
        chk("t5 err_count", 32'(ec[0]), 32'd0);
        txn(0, 32'h20, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t5 old value", rd, 32'h12345678);
        txn(0, 32'hFFFFFFFC, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("top addr err", 32'(er), 32'd1);

        // zero latency, offset base, saturation
        txn(1, 32'h13C, 1, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lc);
        chk("t6 store lat", 32'(lc), 32'd1);
        txn(1, 32'h13C, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t6 load lat", 32'(lc), 32'd1);
        chk("t6 load rdata", rd, 32'h0BADF00D);
        txn(1, 32'hFC, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t6 below base", 32'(er), 32'd1);
        txn(1, 32'h140, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t6 past end", 32'(er), 32'd1);
        txn(1, 32'h100, 1, 32'hFFFFFFFF, 4'h0, 0, 0, rd, er, lc);
        chk("t6 be0 err", 32'(er), 32'd0);
        chk("t6 err_count", 32'(ec[1]), 32'd2);
        for (int j = 0; j < 300; j++) begin
            txn(1, 32'h101 + 32'(j % 3), j[0], 32'h0, 4'hF, 0, 0, rd, er, lc);
        end
        chk("t6 saturated", 32'(ec[1]), 32'd255);
        txn(1, 32'h13C, 0, 32'h0, 4'h0, 0, 0, rd, er, lc);
        chk("t6 intact", rd, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
